interval_timer_ctrl: RTL and testbench



---
 rtl/interval_timer_ctrl.sv | 151 +++++++++++++++
 tb/tb_interval_timer_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/interval_timer_ctrl.sv
// Interval timer initiator: loads a 5/7/8 minute duration on request, counts it down on a
// prescaled 1 s tick and pulses done at expiry. Define RETRIGGER_EN to allow reload while running.
module interval_timer_ctrl #(
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned DUR0     = 300,
  parameter int unsigned DUR1     = 420,
  parameter int unsigned DUR2     = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] sel,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [9:0] remaining,
  output logic [1:0] sel_active
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [9:0]  DUR0_V    = 10'(DUR0);
  localparam logic [9:0]  DUR1_V    = 10'(DUR1);
  localparam logic [9:0]  DUR2_V    = 10'(DUR2);

  state_t      state_q, state_d;
  logic [15:0] prescaler_q, prescaler_d;
  logic [9:0]  remaining_q, remaining_d;
  logic [1:0]  sel_active_q, sel_active_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic start_ok;
  logic start_bad;
  logic tick;

  function automatic logic [9:0] dur_of(input logic [1:0] s);
    case (s)
      2'd0:    dur_of = DUR0_V;
      2'd1:    dur_of = DUR1_V;
      default: dur_of = DUR2_V;
    endcase
  endfunction

  assign start_ok  = start && (sel != 2'd3);
  assign start_bad = start && (sel == 2'd3);
  assign tick      = (prescaler_q == TICK_LAST);

  always_comb begin
    state_d      = state_q;
    prescaler_d  = prescaler_q;
    remaining_d  = remaining_q;
    sel_active_d = sel_active_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      IDLE, FIN: begin
        // FIN lasts exactly one cycle, so done can never stretch.
        state_d = IDLE;
        busy_d  = 1'b0;
        if (start_ok) begin
          state_d      = RUN;
          remaining_d  = dur_of(sel);
          sel_active_d = sel;
          prescaler_d  = '0;
          busy_d       = 1'b1;
        end else if (start_bad) begin
          err_d = 1'b1;
        end
      end

      RUN: begin
        prescaler_d = tick ? 16'd0 : 16'(prescaler_q + 16'd1);
        if (tick) begin
          if (remaining_q <= 10'd1) begin
            remaining_d = '0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            state_d     = FIN;
          end else begin
            remaining_d = remaining_q - 10'd1;
          end
        end
`ifdef RETRIGGER_EN
        // A reload overrides any expiry happening in the same cycle.
        if (start_ok) begin
          state_d      = RUN;
          remaining_d  = dur_of(sel);
          sel_active_d = sel;
          prescaler_d  = '0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
        end else if (start_bad) begin
          err_d = 1'b1;
        end
`endif
        // Abort is evaluated last so it wins over tick and start.
        if (abort) begin
          state_d     = IDLE;
          busy_d      = 1'b0;
          remaining_d = '0;
          prescaler_d = '0;
          done_d      = 1'b0;
          err_d       = 1'b0;
        end
      end

      default: begin
        state_d     = IDLE;
        busy_d      = 1'b0;
        remaining_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      prescaler_q  <= '0;
      remaining_q  <= '0;
      sel_active_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      prescaler_q  <= prescaler_d;
      remaining_q  <= remaining_d;
      sel_active_q <= sel_active_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign remaining  = remaining_q;
  assign sel_active = sel_active_q;

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Directed bench for interval_timer_ctrl: one 1-cycle-tick instance with default durations and
// one TICK_DIV=4 instance with short durations; expectations follow RETRIGGER_EN when defined.
module tb_interval_timer_ctrl;

`ifdef RETRIGGER_EN
  localparam bit RT = 1'b1;
`else
  localparam bit RT = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       start_a, abort_a;
  logic [1:0] sel_a;
  logic       busy_a, done_a, err_a;
  logic [9:0] rem_a;
  logic [1:0] sela_a;
  logic       start_b, abort_b;
  logic [1:0] sel_b;
  logic       busy_b, done_b, err_b;
  logic [9:0] rem_b;
  logic [1:0] sela_b;

  int checks;
  int failures;
  int n;
  int c;

  interval_timer_ctrl u_a (
    .clk(clk), .reset(rst_n), .start(start_a), .sel(sel_a), .abort(abort_a),
    .busy(busy_a), .done(done_a), .err(err_a), .remaining(rem_a), .sel_active(sela_a)
  );

  interval_timer_ctrl #(.TICK_DIV(4), .DUR0(2), .DUR1(3), .DUR2(5)) u_b (
    .clk(clk), .reset(rst_n), .start(start_b), .sel(sel_b), .abort(abort_b),
    .busy(busy_b), .done(done_b), .err(err_b), .remaining(rem_b), .sel_active(sela_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input bit which, input int limit, output int cnt);
    cnt = 0;
    while (((which ? done_b : done_a) !== 1'b1) && (cnt < limit)) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic count_done(input bit which, input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if ((which ? done_b : done_a) === 1'b1) cnt++;
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; sel_a = 2'd0;
    start_b = 1'b0; abort_b = 1'b0; sel_b = 2'd0;

    #3;
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_err", 32'(err_a), 0);
    chk("rst_rem", 32'(rem_a), 0);
    chk("rst_sel", 32'(sela_a), 0);
    chk("rst_b_rem", 32'(rem_b), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // A: sel=0, 300 cycles
    start_a = 1'b1; sel_a = 2'd0;
    @(negedge clk);
    start_a = 1'b0;
    chk("a_busy", 32'(busy_a), 1);
    chk("a_rem0", 32'(rem_a), 300);
    chk("a_sel", 32'(sela_a), 0);
    repeat (150) @(negedge clk);
    chk("a_rem_mid", 32'(rem_a), 150);
    wait_done(1'b0, 400, n);
    chk("a_done_lat", 32'(n), 150);
    chk("a_done_rem", 32'(rem_a), 0);
    chk("a_done_busy", 32'(busy_a), 0);
    @(negedge clk);
    chk("a_done_single", 32'(done_a), 0);

    // B: TICK_DIV=4, sel=1 (3 s)
    start_b = 1'b1; sel_b = 2'd1;
    @(negedge clk);
    start_b = 1'b0;
    chk("b_rem0", 32'(rem_b), 3);
    chk("b_sel", 32'(sela_b), 1);
    chk("b_busy", 32'(busy_b), 1);
    repeat (3) @(negedge clk);
    chk("b_rem_k3", 32'(rem_b), 3);
    @(negedge clk);
    chk("b_rem_k4", 32'(rem_b), 2);
    repeat (4) @(negedge clk);
    chk("b_rem_k8", 32'(rem_b), 1);
    chk("b_done_early", 32'(done_b), 0);
    repeat (4) @(negedge clk);
    chk("b_done_k12", 32'(done_b), 1);
    chk("b_rem_k12", 32'(rem_b), 0);
    chk("b_busy_k12", 32'(busy_b), 0);

    // B: start accepted while in FIN
    start_b = 1'b1; sel_b = 2'd0;
    @(negedge clk);
    start_b = 1'b0;
    chk("b_fin_busy", 32'(busy_b), 1);
    chk("b_fin_rem", 32'(rem_b), 2);
    chk("b_fin_done", 32'(done_b), 0);
    chk("b_fin_sel", 32'(sela_b), 0);
    wait_done(1'b1, 50, n);
    chk("b_fin_lat", 32'(n), 8);
    @(negedge clk);
    chk("b_fin_single", 32'(done_b), 0);

    // A: sel=2, then abort together with start after 10 cycles
    start_a = 1'b1; sel_a = 2'd2;
    @(negedge clk);
    start_a = 1'b0;
    chk("ab_rem0", 32'(rem_a), 480);
    repeat (10) @(negedge clk);
    chk("ab_rem10", 32'(rem_a), 470);
    abort_a = 1'b1; start_a = 1'b1; sel_a = 2'd1;
    @(negedge clk);
    abort_a = 1'b0; start_a = 1'b0;
    chk("ab_busy", 32'(busy_a), 0);
    chk("ab_rem", 32'(rem_a), 0);
    chk("ab_sel", 32'(sela_a), 2);
    count_done(1'b0, 600, c);
    chk("ab_no_done", 32'(c), 0);
    chk("ab_idle_busy", 32'(busy_a), 0);

    // A: invalid select in IDLE
    start_a = 1'b1; sel_a = 2'd3;
    @(negedge clk);
    start_a = 1'b0;
    chk("err_pulse", 32'(err_a), 1);
    chk("err_busy", 32'(busy_a), 0);
    chk("err_rem", 32'(rem_a), 0);
    chk("err_sel", 32'(sela_a), 2);
    @(negedge clk);
    chk("err_single", 32'(err_a), 0);

    // A: asynchronous reset mid-interval at remaining=150
    start_a = 1'b1; sel_a = 2'd1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (270) @(negedge clk);
    chk("ar_rem", 32'(rem_a), 150);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", 32'(busy_a), 0);
    chk("ar_rem0", 32'(rem_a), 0);
    chk("ar_sel0", 32'(sela_a), 0);
    @(negedge clk);
    rst_n = 1'b1;
    count_done(1'b0, 500, c);
    chk("ar_no_done", 32'(c), 0);
    chk("ar_busy_after", 32'(busy_a), 0);

    // A: start during RUN (invalid then valid)
    start_a = 1'b1; sel_a = 2'd0;
    @(negedge clk);
    start_a = 1'b0;
    repeat (49) @(negedge clk);
    start_a = 1'b1; sel_a = 2'd3;
    @(negedge clk);
    start_a = 1'b0;
    chk("rt_err", 32'(err_a), RT ? 1 : 0);
    chk("rt_err_rem", 32'(rem_a), 250);
    chk("rt_err_busy", 32'(busy_a), 1);
    repeat (49) @(negedge clk);
    start_a = 1'b1; sel_a = 2'd2;
    @(negedge clk);
    start_a = 1'b0;
    chk("rt_rem", 32'(rem_a), RT ? 480 : 200);
    chk("rt_sel", 32'(sela_a), RT ? 2 : 0);
    wait_done(1'b0, 1000, n);
    chk("rt_lat", 32'(n), RT ? 480 : 200);
    @(negedge clk);
    chk("rt_single", 32'(done_a), 0);
    count_done(1'b0, 600, c);
    chk("rt_one_done", 32'(c), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
